// File: rtl/sum_bcd_display.sv
// sum_bcd_display: converts a 5-bit adder sum (0..31) into two BCD digits
// with the shift-and-add-3 method, then drives two active-low 7-segment digits.
// One conversion takes 5 SHIFT cycles plus one DONE cycle. The outputs hold
// their value until the next conversion finishes.
module sum_bcd_display #(
  parameter bit BLANK_LZ = 1'b1  // 1: blank HEX1 when the tens digit is 0
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,        // asynchronous active-low reset
  input  logic [4:0] sum_in,
  input  logic       sum_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] bcd,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] HEX1_RST  = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

  state_t      state, state_nx;
  logic [4:0]  shreg;     // binary bits still to be shifted into the scratch
  logic [7:0]  scratch;   // BCD result being built: [7:4] tens, [3:0] ones
  logic [7:0]  adj;       // scratch after the add-3 correction
  logic [2:0]  cnt;       // SHIFT iteration 0..4

  // Active-low segment pattern (g..a) for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Add 3 to each nibble that is 5 or more, so the next left shift carries
  // it correctly into the next decimal digit.
  always_comb begin
    adj[7:4] = (scratch[7:4] >= 4'd5) ? scratch[7:4] + 4'd3 : scratch[7:4];
    adj[3:0] = (scratch[3:0] >= 4'd5) ? scratch[3:0] + 4'd3 : scratch[3:0];
  end

  // Next-state logic and busy flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first. Otherwise a path
    // that leaves it unassigned infers a latch.
    state_nx = state;
    case (state)
      IDLE:    if (sum_valid) state_nx = SHIFT;
      SHIFT:   if (cnt == 3'd4) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy = (state != IDLE);
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together and no register sees another's new value.
    if (!KEY0) state <= IDLE;
    else       state <= state_nx;
  end

  // Conversion datapath: capture, shift/add-3, and publish the result.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      HEX0    <= SEG_ZERO;
      HEX1    <= HEX1_RST;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (sum_valid) begin
            shreg   <= sum_in;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {adj[6:0], shreg, 1'b0};
          if (cnt != 3'd4) cnt <= cnt + 3'd1;
        end
        DONE: begin
          bcd  <= scratch;
          HEX0 <= seg7(scratch[3:0]);
          HEX1 <= (BLANK_LZ && scratch[7:4] == 4'd0) ? SEG_BLANK : seg7(scratch[7:4]);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_bcd_display.sv
// tb_sum_bcd_display: checks two instances of sum_bcd_display, one with
// BLANK_LZ=1 and one with BLANK_LZ=0, against a decimal reference model.
module tb_sum_bcd_display;

  logic       clk = 1'b0;
  logic       key0;
  logic [4:0] sum_in;
  logic       sum_valid;

  logic       busy_a, done_a, busy_b, done_b;
  logic [7:0] bcd_a, bcd_b;
  logic [6:0] hex1_a, hex0_a, hex1_b, hex0_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  sum_bcd_display #(.BLANK_LZ(1'b1)) dut_a (
    .CLOCK_50(clk), .KEY0(key0), .sum_in(sum_in), .sum_valid(sum_valid),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .HEX1(hex1_a), .HEX0(hex0_a)
  );

  sum_bcd_display #(.BLANK_LZ(1'b0)) dut_b (
    .CLOCK_50(clk), .KEY0(key0), .sum_in(sum_in), .sum_valid(sum_valid),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .HEX1(hex1_b), .HEX0(hex0_b)
  );

  // Reference segment table, indexed by decimal digit.
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected published outputs for input value v, on both instances.
  task automatic check_result(input int v);
    int tens, ones;
    tens = v / 10;
    ones = v % 10;
    check("bcd_a", bcd_a, 32'(tens * 16 + ones));
    check("bcd_b", bcd_b, 32'(tens * 16 + ones));
    check("hex0_a", hex0_a, seg_tab[ones]);
    check("hex0_b", hex0_b, seg_tab[ones]);
    check("hex1_a", hex1_a, (tens == 0) ? 7'b1111111 : seg_tab[tens]);
    check("hex1_b", hex1_b, seg_tab[tens]);
  endtask

  task automatic check_reset();
    check("rst_busy", {busy_a, busy_b}, 2'b00);
    check("rst_done", {done_a, done_b}, 2'b00);
    check("rst_bcd", {bcd_a, bcd_b}, 16'h0000);
    check("rst_hex0", {hex0_a, hex0_b}, {7'b1000000, 7'b1000000});
    check("rst_hex1", {hex1_a, hex1_b}, {7'b1111111, 7'b1000000});
  endtask

  // Issue a one-cycle request (called just after a falling edge) and wait for done.
  // On return the caller sits in the IDLE cycle right after the done edge.
  task automatic convert(input int v);
    int lat;
    sum_in    = 5'(v);
    sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
    sum_in    = 5'($urandom_range(0, 31));
    check("busy_on", {busy_a, busy_b, done_a}, 3'b110);
    lat = 0;
    while (!done_a && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 6);
    check("done_b", done_b, 1'b1);
    check("busy_at_done", busy_a, 1'b0);
    check_result(v);
  endtask

  initial begin
    int pulses;
    logic [7:0] held;
    key0      = 1'b0;
    sum_valid = 1'b0;
    sum_in    = '0;
    repeat (2) @(negedge clk);
    check_reset();
    key0 = 1'b1;
    @(negedge clk);

    // Directed values: 30, and 9 on both blanking options.
    convert(30);
    convert(9);
    @(negedge clk);
    check("done_pulse", done_a, 1'b0);

    // A second request two cycles later arrives while busy and is dropped.
    sum_in = 5'd31; sum_valid = 1'b1;
    @(negedge clk); sum_valid = 1'b0;
    @(negedge clk); sum_in = 5'd5; sum_valid = 1'b1;
    @(negedge clk); sum_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (done_a) pulses++;
      @(negedge clk);
    end
    check("one_done", pulses, 1);
    check_result(31);

    // Reset in the third SHIFT cycle aborts with no done pulse.
    sum_in = 5'd16; sum_valid = 1'b1;
    @(negedge clk); sum_valid = 1'b0;
    repeat (2) @(negedge clk);
    key0 = 1'b0;
    #1;
    check_reset();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_a || done_b) pulses++;
    end
    check("abort_no_done", pulses, 0);
    key0 = 1'b1;
    @(negedge clk);
    convert(16);

    // Every input back-to-back: each request is issued on the IDLE cycle after done.
    for (int v = 0; v < 32; v++) convert(v);

    // Random values with random idle gaps; outputs must hold while idle.
    for (int i = 0; i < 20; i++) begin
      int gap;
      gap  = $urandom_range(0, 3);
      held = bcd_a;
      repeat (gap) @(negedge clk);
      check("hold_bcd", bcd_a, held);
      convert($urandom_range(0, 31));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
